// File: rtl/countdown_timer_24hour.sv
// Countdown companion to the 24-hour clock: load hh:mm:ss, run, pause,
// and hold an expiry flag for ALARM_TICKS ticks once it reaches zero.
module countdown_timer_24hour #(
    parameter int ALARM_TICKS = 10,
    parameter int MAX_HOUR    = 23
) (
    input  logic       clk_1Hz,
    input  logic       resetn,
    input  logic       start_stop,
    input  logic       mode_in,
    input  logic       hour_in,
    input  logic       min_in,
    input  logic       sec_in,
    output logic [4:0] hour_out,
    output logic [5:0] min_out,
    output logic [5:0] sec_out,
    output logic       running,
    output logic       expired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INPUT,
        S_COUNT,
        S_PAUSE,
        S_EXPIRED
    } state_t;

    localparam logic [4:0] HMAX = 5'(MAX_HOUR);
    localparam logic [5:0] TLAST = 6'(ALARM_TICKS - 1);

    state_t     state, state_nxt;
    logic [4:0] hour, hour_nxt;
    logic [5:0] min, min_nxt;
    logic [5:0] sec, sec_nxt;
    logic [5:0] tick, tick_nxt;

    logic is_zero;
    logic last_sec;

    assign is_zero  = (hour == 5'd0) && (min == 6'd0) && (sec == 6'd0);
    assign last_sec = (hour == 5'd0) && (min == 6'd0) && (sec == 6'd1);

    always_ff @(posedge clk_1Hz or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            hour  <= '0;
            min   <= '0;
            sec   <= '0;
            tick  <= '0;
        end else begin
            state <= state_nxt;
            hour  <= hour_nxt;
            min   <= min_nxt;
            sec   <= sec_nxt;
            tick  <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hour_nxt  = hour;
        min_nxt   = min;
        sec_nxt   = sec;
        tick_nxt  = tick;
        if (!mode_in) begin
            state_nxt = S_IDLE;
            hour_nxt  = '0;
            min_nxt   = '0;
            sec_nxt   = '0;
            tick_nxt  = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    hour_nxt = '0;
                    min_nxt  = '0;
                    sec_nxt  = '0;
                    if (!start_stop)
                        state_nxt = S_INPUT;
                end
                S_INPUT: begin
                    if (start_stop && !is_zero) begin
                        state_nxt = S_COUNT;
                    end else begin
                        if (hour_in)
                            hour_nxt = (hour >= HMAX) ? 5'd0 : hour + 5'd1;
                        if (min_in)
                            min_nxt = (min >= 6'd59) ? 6'd0 : min + 6'd1;
                        if (sec_in)
                            sec_nxt = (sec >= 6'd59) ? 6'd0 : sec + 6'd1;
                    end
                end
                S_COUNT: begin
                    if (!start_stop) begin
                        state_nxt = S_PAUSE;
                    end else begin
                        // Borrow ripples sec -> min -> hour.
                        if (sec != 6'd0) begin
                            sec_nxt = sec - 6'd1;
                        end else begin
                            sec_nxt = 6'd59;
                            if (min != 6'd0) begin
                                min_nxt = min - 6'd1;
                            end else begin
                                min_nxt  = 6'd59;
                                hour_nxt = hour - 5'd1;
                            end
                        end
                        if (last_sec) begin
                            state_nxt = S_EXPIRED;
                            tick_nxt  = '0;
                        end
                    end
                end
                S_PAUSE: begin
                    if (start_stop)
                        state_nxt = S_COUNT;
                end
                S_EXPIRED: begin
                    hour_nxt = '0;
                    min_nxt  = '0;
                    sec_nxt  = '0;
                    if (tick >= TLAST) begin
                        state_nxt = S_IDLE;
                        tick_nxt  = '0;
                    end else begin
                        tick_nxt = tick + 6'd1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    hour_nxt  = '0;
                    min_nxt   = '0;
                    sec_nxt   = '0;
                    tick_nxt  = '0;
                end
            endcase
        end
    end

    always_comb begin
        hour_out = hour;
        min_out  = min;
        sec_out  = sec;
        running  = (state == S_COUNT);
        expired  = (state == S_EXPIRED);
    end

endmodule
